seq_pattern_gen: RTL

Serial bit-sequence transmitter: accepts a PAT_W-bit pattern through a valid/ready handshake and drives it MSB-first onto a single-bit serial line. The pattern is repeated a programmable number of times, with an optional run of idle cycles between repetitions. It produces stimulus for the team's serial sequence-detector FSMs and sits at the driving end of the same single-bit din line.

---
 rtl/seq_gen_pkg.sv | 12 +
 rtl/seq_pattern_gen.sv | 114 +++++++++++
 2 files changed

// File: rtl/seq_gen_pkg.sv
// Shared constants for the serial pattern generator: FSM state codes and
// the canonical detector stimulus pattern.
package seq_gen_pkg;

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] SHIFT = 2'b01;
   localparam logic [1:0] GAP   = 2'b10;
   localparam logic [1:0] DONE  = 2'b11;

   localparam logic [2:0] DEFAULT_PATTERN = 3'b101;

endpackage

// File: rtl/seq_pattern_gen.sv
// Serial bit-sequence transmitter: sends an accepted pattern MSB-first, repeated
// rep_count times with gap_len idle cycles between repetitions.
module seq_pattern_gen
   import seq_gen_pkg::*;
#(
   parameter int PAT_W = 3,
   parameter int CNT_W = 4,
   parameter int GAP_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PAT_W-1:0] pat_data,
   input  logic [CNT_W-1:0] rep_count,
   input  logic [GAP_W-1:0] gap_len,
   input  logic             pat_valid,
   output logic             pat_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done
);

   // Handshake: a request is taken on any clk edge where pat_valid && pat_ready;
   // pat_ready is only high in IDLE outside reset, and nothing is taken elsewhere.

   localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

   logic [1:0]       state, state_nx;
   logic [PAT_W-1:0] shreg, shreg_nx;
   logic [PAT_W-1:0] saved, saved_nx;
   logic [BW-1:0]    bit_cnt, bit_cnt_nx;
   logic [CNT_W-1:0] reps_left, reps_nx;
   logic [GAP_W-1:0] gap_reg, gap_reg_nx;
   logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;

   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      saved_nx   = saved;
      bit_cnt_nx = bit_cnt;
      reps_nx    = reps_left;
      gap_reg_nx = gap_reg;
      gap_cnt_nx = gap_cnt;
      case (state)
         IDLE: begin
            if (pat_valid) begin
               shreg_nx   = pat_data;
               saved_nx   = pat_data;
               bit_cnt_nx = BW'(PAT_W - 1);
               reps_nx    = (rep_count == '0) ? CNT_W'(1) : rep_count;
               gap_reg_nx = gap_len;
               state_nx   = SHIFT;
            end
         end
         SHIFT: begin
            shreg_nx = shreg << 1;
            if (bit_cnt != '0) begin
               bit_cnt_nx = bit_cnt - BW'(1);
            end else begin
               if (reps_left != '0)
                  reps_nx = reps_left - CNT_W'(1);
               // Decision uses the count before this repetition is retired.
               if (reps_left <= CNT_W'(1)) begin
                  state_nx = DONE;
               end else if (gap_reg != '0) begin
                  gap_cnt_nx = gap_reg - GAP_W'(1);
                  state_nx   = GAP;
               end else begin
                  shreg_nx   = saved;
                  bit_cnt_nx = BW'(PAT_W - 1);
               end
            end
         end
         GAP: begin
            if (gap_cnt != '0) begin
               gap_cnt_nx = gap_cnt - GAP_W'(1);
            end else begin
               shreg_nx   = saved;
               bit_cnt_nx = BW'(PAT_W - 1);
               state_nx   = SHIFT;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shreg     <= '0;
         saved     <= '0;
         bit_cnt   <= '0;
         reps_left <= '0;
         gap_reg   <= '0;
         gap_cnt   <= '0;
      end else begin
         state     <= state_nx;
         shreg     <= shreg_nx;
         saved     <= saved_nx;
         bit_cnt   <= bit_cnt_nx;
         reps_left <= reps_nx;
         gap_reg   <= gap_reg_nx;
         gap_cnt   <= gap_cnt_nx;
      end
   end

   assign pat_ready  = (state == IDLE) && !reset;
   assign dout_valid = (state == SHIFT);
   assign dout       = (state == SHIFT) && shreg[PAT_W-1];
   assign busy       = (state == SHIFT) || (state == GAP);
   assign done       = (state == DONE);

endmodule
